// File: rtl/psr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// psr_trap_ctrl : sequences every PSR write (SAVE/RESTORE, icc, trap, RETT)
//                 plus the PC/nPC local-register saves and the TBR tt write.
// Option macro  : PSR_TRAP_CTRL_WIM_CHECK_EN (WIM checks on save/restore/RETT)
// Revision      : 1.0
// ============================================================================
module psr_trap_ctrl #(
   parameter int NWIN = 8
) (
   input  logic        Clk,
   input  logic        Clr,
   input  logic [31:0] psr_q,
   input  logic [7:0]  wim,
   input  logic        icc_req,
   input  logic [3:0]  icc_new,
   input  logic        save_req,
   input  logic        restore_req,
   input  logic        rett_req,
   input  logic        trap_req,
   input  logic [7:0]  trap_tt,
   output logic        psr_en,
   output logic [3:0]  icc_out,
   output logic [2:0]  cwp_out,
   output logic [1:0]  trap_out,
   output logic        rf_we,
   output logic [1:0]  rf_sel,
   output logic        tbr_we,
   output logic [7:0]  tt_out,
   output logic        ack,
   output logic        busy,
   output logic        error_mode
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_T_PSR = 3'd1,
      S_T_PC  = 3'd2,
      S_T_NPC = 3'd3,
      S_T_TBR = 3'd4,
      S_R_PSR = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_tt, w_tt;
   logic [2:0]  w_cwp, w_cwp_dec, w_cwp_inc, w_cwp_o;
   logic        w_et, w_s, w_wim_dec, w_wim_inc;
   logic        w_psr_en, w_rf_we, w_tbr_we, w_ack;
   logic [3:0]  w_icc;
   logic [1:0]  w_trap, w_rf_sel;
   logic [7:0]  w_tt_out;

   assign w_cwp     = psr_q[2:0];
   assign w_et      = psr_q[5];
   assign w_s       = psr_q[7];
   assign w_cwp_dec = (w_cwp == 3'd0) ? 3'(NWIN - 1) : w_cwp - 3'd1;
   assign w_cwp_inc = (w_cwp == 3'(NWIN - 1)) ? 3'd0 : w_cwp + 3'd1;

`ifdef PSR_TRAP_CTRL_WIM_CHECK_EN
   assign w_wim_dec = wim[w_cwp_dec];
   assign w_wim_inc = wim[w_cwp_inc];
   logic  w_unused;
   assign w_unused  = &{1'b0, psr_q[31:24], psr_q[19:8], psr_q[6], psr_q[4:3]};
`else
   assign w_wim_dec = 1'b0;
   assign w_wim_inc = 1'b0;
   logic  w_unused;
   assign w_unused  = &{1'b0, wim, psr_q[31:24], psr_q[19:8], psr_q[6], psr_q[4:3]};
`endif

   always_comb begin
      w_next   = r_state;
      w_tt     = r_tt;
      w_psr_en = 1'b0;
      w_icc    = psr_q[23:20];
      w_cwp_o  = w_cwp;
      w_trap   = 2'd0;
      w_rf_we  = 1'b0;
      w_rf_sel = 2'd0;
      w_tbr_we = 1'b0;
      w_tt_out = 8'h00;
      w_ack    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (trap_req) begin
               if (w_et) begin
                  w_tt   = trap_tt;
                  w_next = S_T_PSR;
               end else begin
                  w_next = S_ERROR;
               end
            end else if (rett_req) begin
               if (w_et) begin
                  w_tt   = 8'h02;
                  w_next = S_T_PSR;
               end else if (!w_s || w_wim_inc) begin
                  w_next = S_ERROR;
               end else begin
                  w_next = S_R_PSR;
               end
            end else if (save_req) begin
               if (w_wim_dec) begin
                  w_tt   = 8'h05;
                  w_next = S_T_PSR;
               end else begin
                  w_psr_en = 1'b1;
                  w_cwp_o  = w_cwp_dec;
                  w_ack    = 1'b1;
               end
            end else if (restore_req) begin
               if (w_wim_inc) begin
                  w_tt   = 8'h06;
                  w_next = S_T_PSR;
               end else begin
                  w_psr_en = 1'b1;
                  w_cwp_o  = w_cwp_inc;
                  w_ack    = 1'b1;
               end
            end else if (icc_req) begin
               w_psr_en = 1'b1;
               w_icc    = icc_new;
               w_ack    = 1'b1;
            end
         end
         S_T_PSR: w_next = S_T_PC;
         S_T_PC:  w_next = S_T_NPC;
         S_T_NPC: w_next = S_T_TBR;
         S_T_TBR: w_next = S_IDLE;
         S_R_PSR: w_next = S_IDLE;
         S_ERROR: w_next = S_ERROR;
         default: w_next = S_IDLE;
      endcase

      // Outputs are registered, so the strobes belong to the state being entered
      case (w_next)
         S_T_PSR: begin
            w_psr_en = 1'b1;
            w_trap   = 2'd1;
            w_cwp_o  = w_cwp_dec;
         end
         S_T_PC: begin
            w_rf_we  = 1'b1;
            w_rf_sel = 2'd1;
         end
         S_T_NPC: begin
            w_rf_we  = 1'b1;
            w_rf_sel = 2'd2;
         end
         S_T_TBR: begin
            w_tbr_we = 1'b1;
            w_tt_out = r_tt;
            w_ack    = 1'b1;
         end
         S_R_PSR: begin
            w_psr_en = 1'b1;
            w_trap   = 2'd2;
            w_cwp_o  = w_cwp_inc;
            w_ack    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_state    <= S_IDLE;
         r_tt       <= 8'h00;
         psr_en     <= 1'b0;
         icc_out    <= 4'h0;
         cwp_out    <= 3'd0;
         trap_out   <= 2'd0;
         rf_we      <= 1'b0;
         rf_sel     <= 2'd0;
         tbr_we     <= 1'b0;
         tt_out     <= 8'h00;
         ack        <= 1'b0;
         busy       <= 1'b0;
         error_mode <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_tt       <= w_tt;
         psr_en     <= w_psr_en;
         icc_out    <= w_icc;
         cwp_out    <= w_cwp_o;
         trap_out   <= w_trap;
         rf_we      <= w_rf_we;
         rf_sel     <= w_rf_sel;
         tbr_we     <= w_tbr_we;
         tt_out     <= w_tt_out;
         ack        <= w_ack;
         busy       <= (w_next != S_IDLE);
         error_mode <= (w_next == S_ERROR);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psr_trap_ctrl.sv
`default_nettype none
// Directed bench for psr_trap_ctrl with a small PSR register model.
module tb_psr_trap_ctrl;

   logic        Clk = 1'b0;
   logic        Clr;
   logic [31:0] psr_q;
   logic [7:0]  wim;
   logic        icc_req, save_req, restore_req, rett_req, trap_req;
   logic [3:0]  icc_new;
   logic [7:0]  trap_tt;
   logic        psr_en, rf_we, tbr_we, ack, busy, error_mode;
   logic [3:0]  icc_out;
   logic [2:0]  cwp_out;
   logic [1:0]  trap_out, rf_sel;
   logic [7:0]  tt_out;
   logic [24:0] w_all;

   logic        r_ld;
   logic [31:0] r_ld_val;
   int          n_chk = 0;
   int          n_err = 0;

   psr_trap_ctrl #(.NWIN(8)) u_dut (
      .Clk(Clk), .Clr(Clr), .psr_q(psr_q), .wim(wim),
      .icc_req(icc_req), .icc_new(icc_new), .save_req(save_req),
      .restore_req(restore_req), .rett_req(rett_req), .trap_req(trap_req),
      .trap_tt(trap_tt), .psr_en(psr_en), .icc_out(icc_out), .cwp_out(cwp_out),
      .trap_out(trap_out), .rf_we(rf_we), .rf_sel(rf_sel), .tbr_we(tbr_we),
      .tt_out(tt_out), .ack(ack), .busy(busy), .error_mode(error_mode)
   );

   always #5 Clk = ~Clk;

   assign w_all = {psr_en, icc_out, cwp_out, trap_out, rf_we, rf_sel,
                   tbr_we, tt_out, ack, busy, error_mode};

   // PSR register model: applies the write port the way the integer unit would
   always @(posedge Clk) begin
      if (r_ld) begin
         psr_q <= r_ld_val;
      end else if (psr_en) begin
         psr_q[23:20] <= icc_out;
         psr_q[2:0]   <= cwp_out;
         if (trap_out == 2'd1) begin
            psr_q[6] <= psr_q[7];
            psr_q[7] <= 1'b1;
            psr_q[5] <= 1'b0;
         end else if (trap_out == 2'd2) begin
            psr_q[7] <= psr_q[6];
            psr_q[5] <= 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_psr(input logic [31:0] v);
      r_ld_val = v;
      r_ld     = 1'b1;
      tick();
      r_ld     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      Clr = 1'b1; wim = 8'h00; icc_req = 0; icc_new = 4'h0; save_req = 0;
      restore_req = 0; rett_req = 0; trap_req = 0; trap_tt = 8'h00;
      r_ld = 1'b0; r_ld_val = 32'h0;
      set_psr(32'h0);
      tick();
      check("reset_outputs", 32'(w_all), 32'h0);
      Clr = 1'b0;
      tick();

      // SAVE from CWP 0 wraps to 7
      save_req = 1'b1;
      tick();
      check("save_psr_en", 32'(psr_en), 1);
      check("save_cwp", 32'(cwp_out), 7);
      check("save_ack", 32'(ack), 1);
      check("save_busy", 32'(busy), 0);
      save_req = 1'b0;
      tick();
      check("save_ack_pulse", 32'(ack), 0);
      tick();
      check("save_cwp_track", 32'(cwp_out), 7);

      // Trap (tt 0x11, CWP 3) with a concurrent icc request
      set_psr(32'h0000_0023);
      trap_req = 1'b1; trap_tt = 8'h11; icc_req = 1'b1; icc_new = 4'hA;
      tick();
      check("trap_psr_en", 32'(psr_en), 1);
      check("trap_out", 32'(trap_out), 1);
      check("trap_cwp", 32'(cwp_out), 2);
      check("trap_icc_kept", 32'(icc_out), 0);
      check("trap_no_ack", 32'(ack), 0);
      check("trap_busy", 32'(busy), 1);
      tick();
      check("tpc_rf_we", 32'(rf_we), 1);
      check("tpc_rf_sel", 32'(rf_sel), 1);
      check("tpc_psr_en", 32'(psr_en), 0);
      tick();
      check("tnpc_rf_sel", 32'(rf_sel), 2);
      check("tnpc_cwp", 32'(cwp_out), 2);
      tick();
      check("ttbr_we", 32'(tbr_we), 1);
      check("ttbr_tt", 32'(tt_out), 32'h11);
      check("ttbr_ack", 32'(ack), 1);
      trap_req = 1'b0;
      tick();
      check("trap_done_busy", 32'(busy), 0);
      check("trap_done_tbr", 32'(tbr_we), 0);
      tick();
      check("icc_psr_en", 32'(psr_en), 1);
      check("icc_value", 32'(icc_out), 32'hA);
      check("icc_ack", 32'(ack), 1);
      icc_req = 1'b0;
      tick();
      tick();
      check("icc_track", 32'(icc_out), 32'hA);

      // RESTORE from CWP 7 into invalid window 0
      set_psr(32'h0000_0007);
      wim = 8'h01;
      restore_req = 1'b1;
      tick();
`ifdef PSR_TRAP_CTRL_WIM_CHECK_EN
      check("rst_trap_out", 32'(trap_out), 1);
      check("rst_trap_cwp", 32'(cwp_out), 6);
      tick(); tick(); tick();
      check("rst_tt", 32'(tt_out), 32'h06);
      check("rst_ack", 32'(ack), 1);
`else
      check("rst_cwp", 32'(cwp_out), 0);
      check("rst_ack", 32'(ack), 1);
      check("rst_trap_out", 32'(trap_out), 0);
`endif
      restore_req = 1'b0;
      wim = 8'h00;
      tick();
      check("rst_idle", 32'(busy), 0);

      // RETT with ET=0, S=1, CWP 2
      set_psr(32'h0000_0082);
      rett_req = 1'b1;
      tick();
      check("rett_trap_out", 32'(trap_out), 2);
      check("rett_cwp", 32'(cwp_out), 3);
      check("rett_ack", 32'(ack), 1);
      check("rett_psr_en", 32'(psr_en), 1);
      rett_req = 1'b0;
      tick();
      check("rett_done", 32'(busy), 0);

      // RETT from CWP 7 into an invalid window 0
      set_psr(32'h0000_0087);
      wim = 8'h01;
      rett_req = 1'b1;
      tick();
`ifdef PSR_TRAP_CTRL_WIM_CHECK_EN
      check("rett_wim_err", 32'(error_mode), 1);
      check("rett_wim_psr_en", 32'(psr_en), 0);
`else
      check("rett_wrap_cwp", 32'(cwp_out), 0);
      check("rett_wrap_out", 32'(trap_out), 2);
`endif
      rett_req = 1'b0;
      wim = 8'h00;
      Clr = 1'b1;
      tick();
      Clr = 1'b0;

      // RETT with ET=0, S=0 is fatal until Clr
      set_psr(32'h0000_0002);
      rett_req = 1'b1;
      tick();
      check("err_mode", 32'(error_mode), 1);
      check("err_busy", 32'(busy), 1);
      check("err_no_ack", 32'(ack), 0);
      rett_req = 1'b0;
      save_req = 1'b1;
      tick(); tick();
      check("err_sticky", 32'(error_mode), 1);
      check("err_no_psr_en", 32'(psr_en), 0);
      save_req = 1'b0;
      Clr = 1'b1;
      tick();
      check("err_cleared", 32'(error_mode), 0);
      Clr = 1'b0;

      // Clr during T_NPC aborts the trap
      set_psr(32'h0000_0020);
      trap_req = 1'b1; trap_tt = 8'h33;
      tick();
      check("abort_cwp_wrap", 32'(cwp_out), 7);
      tick();
      tick();
      check("abort_in_tnpc", 32'(rf_sel), 2);
      Clr = 1'b1; trap_req = 1'b0;
      tick();
      check("abort_outputs", 32'(w_all), 32'h0);
      Clr = 1'b0;
      tick();
      check("abort_no_tbr", 32'(tbr_we), 0);
      check("abort_idle", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
